coeff_token_ctrl: RTL and testbench
===================================

// Module: coeff_token_ctrl
// PURPOSE
//  Sequencer for CAVLC coeff_token encoding. Accepts one block's TotalCoeff/TrailingOnes plus
//  neighbour counts, computes nC, and drives the shared lookup bus of the four registered
//  coeff_token VLC ROMs. It computes the 6-bit FLC itself when nC>=8, then hands
//  {code,len} to the bitstream packer over a valid/ready handshake. One block is in flight at a time.
// PARAMETERS
//  ROM_LAT  1  read latency of external coeff_token ROMs, in clk edges (1..3)
// PORTS
//  clk              in   1      clock
//  rst              in   1      synchronous reset, active-high
//  in_valid         in   1      request valid
//  in_ready         out  1      controller can accept a request
//  total_coeff_i    in   5      TotalCoeff, 0..16
//  trailing_ones_i  in   2      TrailingOnes, 0..3
//  chroma_dc_i      in   1      block is chroma DC (nC=-1 table)
//  nA_avail_i       in   1      left neighbour available
//  nA_i             in   5      left neighbour TotalCoeff
//  nB_avail_i       in   1      top neighbour available
//  nB_i             in   5      top neighbour TotalCoeff
//  tbl_tc_o         out  5      TotalCoeff address to all ROMs
//  tbl_t1_o         out  2      TrailingOnes address to all ROMs
//  tbl_code_i[0:3]  in   16     ROM CodeBit: 0=chromaDC, 1=0<=nC<2, 2=2<=nC<4, 3=4<=nC<8
//  tbl_len_i[0:3]   in   5      ROM CodeLength, same indexing
//  out_valid        out  1      code_o/len_o valid
//  out_ready        in   1      packer accepts
//  code_o           out  16     codeword, right-justified, upper bits zero
//  len_o            out  5      codeword length, 1..16
//  nc_o             out  6      computed nC (unsigned; 0 when chroma DC)
//  err_o            out  1      one-cycle pulse: illegal request dropped
// BEHAVIOUR
//  Clocking/reset: one clock; every flop is reset synchronously when rst=1.
//  Reset values: state=IDLE, in_ready=1, out_valid=0, err_o=0, and tbl_tc_o, tbl_t1_o,
//   code_o, len_o, nc_o all 0.
//  FSM: IDLE -> WAIT -> OUT -> IDLE.
//   IDLE:
//    - in_ready=1.
//    - On in_valid, capture all inputs, compute nC and the table select, and go to WAIT.
//    - If the request is illegal, pulse err_o, capture nothing, and stay in IDLE.
//   WAIT:
//    - in_ready=0.
//    - tbl_tc_o/tbl_t1_o come from the capture registers and are held stable.
//    - A counter runs ROM_LAT cycles. On the last one, register the selected code/len
//      (or the FLC) into code_o/len_o, set out_valid=1, and go to OUT.
//   OUT:
//    - Hold code_o/len_o/nc_o and out_valid until out_valid&out_ready.
//    - Then clear out_valid and go to IDLE. The next request can be accepted the following cycle.
//  Latency: accept in cycle 0 -> out_valid first high in cycle ROM_LAT+1.
//   Same latency for ROM and FLC paths.
//  Throughput: at most 1 request per ROM_LAT+2 cycles.
//  nC:
//   - both neighbours available: (nA+nB+1)>>1, with a 6-bit sum (max 33 -> nC 16).
//   - only A available: nA.   only B available: nB.   neither available: 0.
//   - chroma_dc_i=1 overrides: table 0, and nc_o=0.
//  Table select: nC<2 -> 1, nC<4 -> 2, nC<8 -> 3, nC>=8 -> FLC.
//  FLC (6 bits, len_o=6):
//   - TotalCoeff==0: code 6'b000011.
//   - otherwise: {TotalCoeff-1 [3:0], TrailingOnes}.
//  Illegal requests:
//   - TotalCoeff>16.
//   - TrailingOnes>TotalCoeff.
//   - TrailingOnes>3 cannot occur (2-bit port).
//   - chroma_dc_i=1 with TotalCoeff>4.
//  Backpressure: out_ready low never alters outputs. out_ready with out_valid=0 is ignored.
//  in_valid outside IDLE is ignored; the requester holds it until in_ready.
//  rst mid-operation: the in-flight block is discarded with no output; next cycle is IDLE.
// TESTING
//  1. chroma_dc_i=0, nA=5/nB=4 both available, tc=3, t1=3 -> nc_o=5, table 3, code_o=16'h000C, len_o=4.
//  2. nA=10 available, B not available, tc=5, t1=2 -> FLC code_o=6'b010010, len_o=6, nc_o=10.
//  3. neither neighbour available, nA=9/nB=9 presented, tc=0, t1=0 -> nc_o=0, table 1 selected
//     (tbl_code_i[1]/tbl_len_i[1] passed through).
//  4. out_ready held low 3 cycles after out_valid -> code_o/len_o stable, no new accept; handshake in cycle 4 -> in_ready=1 next cycle.
//  5. tc=1, t1=2 -> err_o=1 for one cycle, out_valid stays 0, in_ready stays 1. chroma_dc_i=1, tc=5 -> same.
//  6. rst in WAIT -> out_valid 0, all outputs 0. Then back-to-back requests -> spacing exactly ROM_LAT+2 cycles.

Source files
------------

// File: rtl/coeff_token_ctrl.sv
// -----------------------------------------------------------------------------
// coeff_token_ctrl
//   Sequencer for CAVLC coeff_token encoding. Takes one block's TotalCoeff and
//   TrailingOnes plus neighbour counts, derives nC and the VLC table select,
//   addresses the four shared coeff_token ROMs, and returns {code,len} to the
//   bitstream packer. When nC >= 8 the 6-bit fixed-length code is built here
//   instead of using a ROM. Only one block is in flight at a time.
//
// Parameters
//   ROM_LAT          read latency of the external ROMs in clk edges (1..3)
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   in_valid/in_ready        request handshake
//   total_coeff_i    TotalCoeff 0..16
//   trailing_ones_i  TrailingOnes 0..3
//   chroma_dc_i      block is chroma DC (nC = -1 table)
//   nA_avail_i/nA_i  left neighbour availability / TotalCoeff
//   nB_avail_i/nB_i  top neighbour availability / TotalCoeff
//   tbl_tc_o/tbl_t1_o        ROM address bus (shared by all four ROMs)
//   tbl_code_i/tbl_len_i     ROM data: 0=chromaDC, 1=nC<2, 2=nC<4, 3=nC<8
//   out_valid/out_ready      result handshake
//   code_o/len_o     right-justified codeword and its length
//   nc_o             computed nC (0 for chroma DC)
//   err_o            one-cycle pulse when an illegal request is dropped
// -----------------------------------------------------------------------------
module coeff_token_ctrl #(
    parameter int ROM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  total_coeff_i,
    input  logic [1:0]  trailing_ones_i,
    input  logic        chroma_dc_i,
    input  logic        nA_avail_i,
    input  logic [4:0]  nA_i,
    input  logic        nB_avail_i,
    input  logic [4:0]  nB_i,
    output logic [4:0]  tbl_tc_o,
    output logic [1:0]  tbl_t1_o,
    input  logic [15:0] tbl_code_i [0:3],
    input  logic [4:0]  tbl_len_i  [0:3],
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] code_o,
    output logic [4:0]  len_o,
    output logic [5:0]  nc_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    localparam logic [1:0] CNT_LAST = 2'(ROM_LAT - 1);

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [1:0]  sel_q;       // ROM table index
    logic        flc_q;       // nC >= 8: fixed-length code path
    logic [4:0]  tc_q;
    logic [1:0]  t1_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [15:0] code_q;
    logic [4:0]  len_q;
    logic [5:0]  nc_q;
    logic        err_q;

    // ---------------- request decode (used only while IDLE) ----------------
    logic [5:0] sum_ab;
    logic [5:0] nc_d;
    logic [1:0] sel_d;
    logic       flc_d;
    logic       illegal_d;

    // 6-bit sum so 16+16+1 = 33 does not wrap before the halving.
    assign sum_ab = {1'b0, nA_i} + {1'b0, nB_i} + 6'd1;

    always_comb begin
        nc_d      = 6'd0;
        sel_d     = 2'd1;
        flc_d     = 1'b0;
        illegal_d = 1'b0;

        if (nA_avail_i && nB_avail_i) begin
            nc_d = sum_ab >> 1;
        end else if (nA_avail_i) begin
            nc_d = {1'b0, nA_i};
        end else if (nB_avail_i) begin
            nc_d = {1'b0, nB_i};
        end

        if (chroma_dc_i) begin
            // Chroma DC uses its own table regardless of neighbours.
            nc_d  = 6'd0;
            sel_d = 2'd0;
        end else if (nc_d < 6'd2) begin
            sel_d = 2'd1;
        end else if (nc_d < 6'd4) begin
            sel_d = 2'd2;
        end else if (nc_d < 6'd8) begin
            sel_d = 2'd3;
        end else begin
            sel_d = 2'd3;
            flc_d = 1'b1;
        end

        if ((total_coeff_i > 5'd16) ||
            ({3'b000, trailing_ones_i} > total_coeff_i) ||
            (chroma_dc_i && (total_coeff_i > 5'd4))) begin
            illegal_d = 1'b1;
        end
    end

    // ---------------- fixed-length code for nC >= 8 ----------------
    logic [3:0] tc_m1;
    logic [5:0] flc_code;

    assign tc_m1    = 4'(tc_q - 5'd1);
    assign flc_code = (tc_q == 5'd0) ? 6'b000011 : {tc_m1, t1_q};

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            sel_q       <= 2'd0;
            flc_q       <= 1'b0;
            tc_q        <= 5'd0;
            t1_q        <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            code_q      <= 16'd0;
            len_q       <= 5'd0;
            nc_q        <= 6'd0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (illegal_d) begin
                            err_q <= 1'b1;
                        end else begin
                            tc_q       <= total_coeff_i;
                            t1_q       <= trailing_ones_i;
                            sel_q      <= sel_d;
                            flc_q      <= flc_d;
                            nc_q       <= nc_d;
                            cnt_q      <= 2'd0;
                            in_ready_q <= 1'b0;
                            state_q    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // FLC path waits the same number of cycles so latency
                    // does not depend on nC.
                    if (cnt_q == CNT_LAST) begin
                        if (flc_q) begin
                            code_q <= {10'd0, flc_code};
                            len_q  <= 5'd6;
                        end else begin
                            code_q <= tbl_code_i[sel_q];
                            len_q  <= tbl_len_i[sel_q];
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign tbl_tc_o  = tc_q;
    assign tbl_t1_o  = t1_q;
    assign code_o    = code_q;
    assign len_o     = len_q;
    assign nc_o      = nc_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_coeff_token_ctrl.sv
module tb_coeff_token_ctrl;

    localparam int ROM_LAT = 1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  total_coeff;
    logic [1:0]  trailing_ones;
    logic        chroma_dc;
    logic        na_avail;
    logic [4:0]  na;
    logic        nb_avail;
    logic [4:0]  nb;
    logic [4:0]  tbl_tc;
    logic [1:0]  tbl_t1;
    logic [15:0] tbl_code [0:3];
    logic [4:0]  tbl_len  [0:3];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] code;
    logic [4:0]  len;
    logic [5:0]  nc;
    logic        err;

    int checks = 0;
    int errors = 0;

    coeff_token_ctrl #(.ROM_LAT(ROM_LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .total_coeff_i   (total_coeff),
        .trailing_ones_i (trailing_ones),
        .chroma_dc_i     (chroma_dc),
        .nA_avail_i      (na_avail),
        .nA_i            (na),
        .nB_avail_i      (nb_avail),
        .nB_i            (nb),
        .tbl_tc_o        (tbl_tc),
        .tbl_t1_o        (tbl_t1),
        .tbl_code_i      (tbl_code),
        .tbl_len_i       (tbl_len),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .code_o          (code),
        .len_o           (len),
        .nc_o            (nc),
        .err_o           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request (call at a negedge).
    task automatic drive(input logic [4:0] tc, input logic [1:0] t1, input logic cdc,
                         input logic aav, input logic [4:0] a,
                         input logic bav, input logic [4:0] b);
        total_coeff   = tc;
        trailing_ones = t1;
        chroma_dc     = cdc;
        na_avail      = aav;
        na            = a;
        nb_avail      = bav;
        nb            = b;
        in_valid      = 1'b1;
    endtask

    // Issue a legal request, wait for out_valid, check results, then hand it off.
    task automatic run(input string tag, input logic [4:0] tc, input logic [1:0] t1,
                       input logic cdc, input logic aav, input logic [4:0] a,
                       input logic bav, input logic [4:0] b,
                       input logic [5:0] enc, input logic [15:0] ecode,
                       input logic [4:0] elen, input logic handoff);
        int lat;
        drive(tc, t1, cdc, aav, a, bav, b);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        chk({tag, "_addr"}, {25'd0, tbl_tc, tbl_t1}, {25'd0, tc, t1});
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(ROM_LAT + 1));
        chk({tag, "_nc"}, 32'(nc), 32'(enc));
        chk({tag, "_code"}, 32'(code), 32'(ecode));
        chk({tag, "_len"}, 32'(len), 32'(elen));
        $display("txn %s: tc=%0d t1=%0d nc=%0d code=%0h len=%0d lat=%0d",
                 tag, tc, t1, nc, code, len, lat);
        if (handoff) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
            chk({tag, "_done_ready"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int acc [$];
        logic seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        total_coeff = '0; trailing_ones = '0; chroma_dc = 1'b0;
        na_avail = 1'b0; na = '0; nb_avail = 1'b0; nb = '0;
        tbl_code[0] = 16'h0011; tbl_len[0] = 5'd7;
        tbl_code[1] = 16'h0022; tbl_len[1] = 5'd8;
        tbl_code[2] = 16'h0033; tbl_len[2] = 5'd9;
        tbl_code[3] = 16'h000C; tbl_len[3] = 5'd4;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code_len", {11'd0, code, len}, 32'd0);
        chk("rst_nc_addr", {19'd0, nc, tbl_tc, tbl_t1}, 32'd0);
        $display("txn reset: in_ready=%0b out_valid=%0b", in_ready, out_valid);

        // Both neighbours: (5+4+1)>>1 = 5 -> table 3.
        run("t1_tab3", 5'd3, 2'd3, 1'b0, 1'b1, 5'd5, 1'b1, 5'd4, 6'd5, 16'h000C, 5'd4, 1'b1);
        // Only A: nC = 10 -> FLC {0100,10}.
        run("t2_flc", 5'd5, 2'd2, 1'b0, 1'b1, 5'd10, 1'b0, 5'd0, 6'd10, 16'h0012, 5'd6, 1'b1);
        // Neither available, values presented but ignored -> nC 0, table 1.
        run("t3_none", 5'd0, 2'd0, 1'b0, 1'b0, 5'd9, 1'b0, 5'd9, 6'd0, 16'h0022, 5'd8, 1'b1);
        // Chroma DC overrides neighbours: table 0, nC 0.
        run("chroma", 5'd2, 2'd1, 1'b1, 1'b1, 5'd12, 1'b1, 5'd12, 6'd0, 16'h0011, 5'd7, 1'b1);
        // (1+2+1)>>1 = 2 -> table 2 boundary.
        run("nc2", 5'd4, 2'd1, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 6'd2, 16'h0033, 5'd9, 1'b1);
        // Only B: nC = 1 -> table 1.
        run("nc1_b", 5'd2, 2'd2, 1'b0, 1'b0, 5'd0, 1'b1, 5'd1, 6'd1, 16'h0022, 5'd8, 1'b1);
        // (3+4+1)>>1 = 4 -> table 3 boundary.
        run("nc4", 5'd1, 2'd0, 1'b0, 1'b1, 5'd3, 1'b1, 5'd4, 6'd4, 16'h000C, 5'd4, 1'b1);
        // (7+8+1)>>1 = 8 -> FLC boundary, tc=1 t1=1 -> 000001.
        run("nc8", 5'd1, 2'd1, 1'b0, 1'b1, 5'd7, 1'b1, 5'd8, 6'd8, 16'h0001, 5'd6, 1'b1);
        // Max sum 33 -> nC 16, tc=16 t1=3 -> 111111.
        run("nc16", 5'd16, 2'd3, 1'b0, 1'b1, 5'd16, 1'b1, 5'd16, 6'd16, 16'h003F, 5'd6, 1'b1);
        // FLC with TotalCoeff 0 -> 000011.
        run("flc_tc0", 5'd0, 2'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 6'd9, 16'h0003, 5'd6, 1'b1);

        // Backpressure: out_ready low for 3 cycles, a pending in_valid is not taken.
        run("t4_bp", 5'd3, 2'd3, 1'b0, 1'b1, 5'd5, 1'b1, 5'd4, 6'd5, 16'h000C, 5'd4, 1'b0);
        drive(5'd7, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_code", {11'd0, code, len}, {11'd0, 16'h000C, 5'd4});
            chk("t4_hold_busy", 32'(in_ready), 32'd0);
            chk("t4_hold_addr", 32'(tbl_tc), 32'd3);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("t4_release_valid", 32'(out_valid), 32'd0);
        chk("t4_release_ready", 32'(in_ready), 32'd1);
        $display("txn t4_bp: released after 3 stalled cycles");

        // Illegal: TrailingOnes > TotalCoeff.
        drive(5'd1, 2'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t5a_err", 32'(err), 32'd1);
        chk("t5a_valid", 32'(out_valid), 32'd0);
        chk("t5a_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("t5a_err_clear", 32'(err), 32'd0);
        chk("t5a_valid2", 32'(out_valid), 32'd0);
        $display("txn t5a: illegal tc=1 t1=2 dropped");
        // Illegal: chroma DC with TotalCoeff 5.
        drive(5'd5, 2'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t5b_err", 32'(err), 32'd1);
        chk("t5b_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("t5b_err_clear", 32'(err), 32'd0);
        chk("t5b_valid", 32'(out_valid), 32'd0);
        $display("txn t5b: illegal chroma tc=5 dropped");
        // Illegal: TotalCoeff 17.
        drive(5'd17, 2'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t5c_err", 32'(err), 32'd1);
        @(negedge clk);
        $display("txn t5c: illegal tc=17 dropped");

        // Reset while waiting on the ROM.
        drive(5'd3, 2'd3, 1'b0, 1'b1, 5'd5, 1'b1, 5'd4);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'd1);
        chk("t6_rst_code_len", {11'd0, code, len}, 32'd0);
        chk("t6_rst_nc_addr", {19'd0, nc, tbl_tc, tbl_t1}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("t6_no_output", 32'(seen), 32'd0);
        $display("txn t6_rst: in-flight block discarded");

        // Back-to-back with a willing packer: accepts every ROM_LAT+2 cycles.
        drive(5'd2, 2'd1, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (in_valid && in_ready) acc.push_back(c);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t6_accept_count", 32'(acc.size()), 32'd4);
        for (int i = 1; i < acc.size(); i++) begin
            chk("t6_spacing", 32'(acc[i] - acc[i-1]), 32'(ROM_LAT + 2));
            $display("txn t6_b2b: accept at cycle %0d (previous %0d)", acc[i], acc[i-1]);
        end
        chk("t6_b2b_code", {11'd0, code, len}, {11'd0, 16'h0033, 5'd9});
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global timeout so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
